// File: rtl/sync_down_timer.sv
// Loadable synchronous down-counter/timer: counts a loaded value to zero on
// enabled clocks, pulses tc at zero, then stops (one-shot) or reloads (periodic).
module sync_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // State register and datapath registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-datapath logic; load takes priority over counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    if (load) begin
      reload_d = load_val;
      mode_d   = mode;
      cnt_d    = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (en) begin
            if (cnt_q > WIDTH'(1)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else if (cnt_q == WIDTH'(1)) begin
              cnt_d = '0;
              tc_d  = 1'b1;
              if (!mode_q) state_d = DONE;
            end else if (mode_q) begin
              // Zero in RUN only happens in periodic mode: the extra reload cycle.
              cnt_d = reload_q;
            end
          end
        end
        DONE: state_d = DONE;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == RUN);
  end

  // Outputs come straight from registers.
  always_comb begin
    counter = cnt_q;
    tc      = tc_q;
    busy    = busy_q;
  end

endmodule

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Loadable synchronous down-counter/timer. It is the count-down counterpart of the team's free-running synchronous up counter.
- Counts from a loaded value to zero, one step per enabled clock.
- Flags terminal count with a one-cycle pulse.
- Either stops at zero (one-shot) or reloads and repeats (periodic). Intended as the interval/timeout source beside the up counter.

Parameters:
- WIDTH, 4, bit width of the count, load value and reload register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
- en  input  1  count enable; decrement or reload only when high.
- load  input  1  load strobe; captures load_val and mode.
- load_val  input  WIDTH  start/reload value.
- mode  input  1  0 = one-shot, 1 = periodic; latched on load.
- counter  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered), high for exactly one cycle.
- busy  output  1  high while the state machine is in RUN (registered).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Internal state: FSM {IDLE, RUN, DONE}, reload_reg[WIDTH], mode_reg.
- Reset: when rst=1 at an edge, the next values are counter=0, tc=0, busy=0, state=IDLE, reload_reg=0, mode_reg=0. rst overrides load and en. Reset mid-count aborts with no tc.
- Priority per edge: rst > load > en-driven counting.
- tc defaults to 0 on every edge unless set by the rule below.
- load=1 (any state, en ignored that cycle):
  - reload_reg<=load_val, mode_reg<=mode, counter<=load_val.
  - If load_val!=0: state<=RUN, busy<=1. If load_val==0: state<=IDLE, busy<=0.
  - No tc on a load edge.
- IDLE: counter holds; en ignored; tc=0.
- RUN with en=0: counter, state and busy hold; tc=0.
- RUN with en=1:
  - counter>1: counter<=counter-1.
  - counter==1: counter<=0, tc<=1. If mode_reg=0: state<=DONE, busy<=0. If mode_reg=1: stay RUN.
  - counter==0 (periodic only): counter<=reload_reg, tc<=0. Periodic period = reload_reg+1 enabled cycles.
- DONE: counter holds 0, busy=0, tc=0; leaves only on load or rst.
- Latency and timing:
  - Load value visible on counter the edge after load.
  - tc is high in the same cycle counter first reads 0.
- No underflow: the counter never wraps from 0 to all-ones. The maximum load value 2^WIDTH-1 counts down normally.
- mode changes while running have no effect until the next load.
- Unknown state encodings recover to IDLE.

Test Plan:
- Reset: rst=1 for 2 cycles with load=1, load_val=7 -> counter=0, tc=0, busy=0; release rst, en=1, no load -> counter stays 0, no tc.
- One-shot: load_val=5, mode=0, then en=1 -> counter 5,4,3,2,1,0. tc=1 only in the cycle counter=0. busy falls on the same edge. Counter holds 0 with no further tc for 10 cycles.
- Periodic: load_val=3, mode=1, en=1 -> counter 3,2,1,0,3,2,1,0,3. tc high at each 0, every 4 cycles. busy stays 1.
- Enable gating: load 4 one-shot; en=1 two cycles (counter 2); en=0 three cycles -> counter holds 2, tc=0. en=1 -> 1, 0 with tc once.
- Load collision: periodic load 15, en=1; at counter=9 assert load=1, load_val=6, en=1 -> next counter=6, not 8, no tc; then counts to 0. Separately, load_val=0 -> state IDLE, busy=0, no tc ever.
- Reset mid-run: load 15 periodic, count to 6, rst=1 one cycle -> counter=0, busy=0, tc=0. Stays IDLE with en=1 until next load.
